tlb_op_sequencer: RTL and testbench
===================================

TLB_OP_SEQUENCER -- requirements
Module: tlb_op_sequencer

Interface
REQ-001 The module SHALL have the following ports (name direction width meaning), clock and reset first:
 Clk in 1: single clock; all state on rising edge.
 Rest in 1: synchronous, active-high reset.
 Flush in 1: pipeline flush; aborts in-flight op.
 ReqValid in 1 / ReqReady out 1: op request handshake.
 ReqOp in 3: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 illegal.
 ReqIndex in 6: TLB index for RD/WR.
 ReqEntry in 89: entry image for WR/FILL.
 ReqAsid in 10 / ReqVppn in 19: search key and INV operands.
 ReqInvOp in 5: INVTLB op code.
 RespValid out 1: one-cycle completion pulse.
 RespOp out 3: op being completed.
 RespHit out 1: SRCH hit.
 RespIndex out 6: result index.
 RespEntry out 89: RD data.
 RespErr out 1: illegal op.
 FlushReq out 1: front-end refetch request after TLB modification.
 MmuSerchAble out 1 / MmuSerchInfrom out 29 {vppn,asid}: MMU search port.
 MmuSerchHit in 1 / MmuSerchIdx in 6: registered search result.
 MmuReadAddr out 6 / MmuReadDate in 89: read port.
 MmuWriteAble out 1 / MmuWriteAddr out 6 / MmuWriteDate out 89: write port.
 MmuInvEn out 1 / MmuInvOp out 5 / MmuInvAsid out 10 / MmuInvVppn out 19: invalidate port.
REQ-002 The design SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, advancing IDLE->ISSUE->WAIT->RESP->IDLE.
REQ-004 ReqReady SHALL be 1 only in IDLE; ReqValid outside IDLE SHALL be ignored.
REQ-005 On ReqValid&ReqReady, all Req* fields SHALL be latched and the FSM SHALL enter ISSUE.
REQ-006 In ISSUE the strobes SHALL be driven for exactly that cycle: SRCH -> MmuSerchAble; WR/FILL -> MmuWriteAble; INV -> MmuInvEn.
REQ-007 The strobes SHALL be 0 in all other states.
REQ-008 For RD, MmuReadAddr SHALL equal the latched index during ISSUE and WAIT.
REQ-009 WR SHALL write to the latched ReqIndex; FILL SHALL write to the fill index (REQ-017).
REQ-010 In WAIT the module SHALL capture MmuSerchHit/MmuSerchIdx for SRCH and MmuReadDate for RD.
REQ-011 RESP SHALL assert RespValid for one cycle; accept-to-RespValid latency SHALL be 3 cycles.
REQ-012 RespIndex SHALL be: SRCH -> MmuSerchIdx; RD/WR -> ReqIndex; FILL -> chosen fill index; INV -> 0.
REQ-013 RespHit and RespEntry SHALL be 0 except for SRCH and RD respectively.
REQ-014 FlushReq SHALL pulse with RespValid for WR, FILL and legal INV.
REQ-015 Illegal ReqOp, or INV with ReqInvOp>6, SHALL issue no MMU strobe; the op SHALL follow the same 3-cycle path with RespErr=1 and FlushReq=0.
REQ-016 Flush SHALL act as follows:
 - in ISSUE: suppress the strobe and go to IDLE with no response;
 - in WAIT/RESP: go to IDLE and force RespValid/FlushReq to 0 (a write already issued stands);
 - in IDLE: no effect.
REQ-017 The fill index SHALL advance only when a FILL strobe is actually issued.

Reset
REQ-018 Rest SHALL have priority over Flush and ReqValid.
REQ-019 Rest SHALL force IDLE with every output 0 except ReqReady=1.
REQ-020 Rest SHALL clear all latched fields and reset the fill-index generator to its seed.
REQ-021 Rest asserted mid-operation SHALL drop the op without response or further strobe.

Configuration
REQ-022 With TLB_FILL_LFSR_EN defined, the fill index SHALL come from a 6-bit Fibonacci LFSR (x^6+x^5+1, seed 6'b000001) cycling the 63 nonzero values; index 0 is never used by FILL.
REQ-023 Without TLB_FILL_LFSR_EN, the fill index SHALL come from a 6-bit counter with reset value 0 that wraps from 63 to 0.

Verification
REQ-024 SRCH with ReqVppn=19'h1234, ReqAsid=10'h5, MMU returning hit at idx 6'd17 -> one MmuSerchAble pulse with Infrom={19'h1234,10'h5}; RespValid 3 cycles after accept with RespHit=1, RespIndex=17, FlushReq=0.
REQ-025 RD at index 6'd42 with MmuReadDate=89'hABC -> MmuReadAddr=42 in ISSUE and WAIT; RespEntry=89'hABC, RespIndex=42.
REQ-026 Three back-to-back FILLs after reset -> write indices 0,1,2 without the macro, or 1,2,4 with the macro; each response has FlushReq=1.
REQ-027 INV with ReqInvOp=5'd7, and separately ReqOp=3'd6 -> no MmuInvEn/strobe; RespErr=1, RespValid on cycle 3.
REQ-028 WR accepted, then Flush in ISSUE -> no MmuWriteAble, no RespValid, ReqReady=1 next cycle.
REQ-029 WR accepted, then Flush in WAIT -> exactly one MmuWriteAble, no RespValid/FlushReq.
REQ-030 Rest raised during WAIT -> all outputs 0 and ReqReady=1 the next cycle.

Source files
------------

// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: serialises SRCH/RD/WR/FILL/INV requests onto the MMU TLB ports, one op in flight.
// Build option: define TLB_FILL_LFSR_EN to choose FILL victims from a 6-bit LFSR instead of a counter.
module tlb_op_sequencer (
   input  logic        Clk,
   input  logic        Rest,
   input  logic        Flush,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [2:0]  ReqOp,
   input  logic [5:0]  ReqIndex,
   input  logic [88:0] ReqEntry,
   input  logic [9:0]  ReqAsid,
   input  logic [18:0] ReqVppn,
   input  logic [4:0]  ReqInvOp,
   output logic        RespValid,
   output logic [2:0]  RespOp,
   output logic        RespHit,
   output logic [5:0]  RespIndex,
   output logic [88:0] RespEntry,
   output logic        RespErr,
   output logic        FlushReq,
   output logic        MmuSerchAble,
   output logic [28:0] MmuSerchInfrom,
   input  logic        MmuSerchHit,
   input  logic [5:0]  MmuSerchIdx,
   output logic [5:0]  MmuReadAddr,
   input  logic [88:0] MmuReadDate,
   output logic        MmuWriteAble,
   output logic [5:0]  MmuWriteAddr,
   output logic [88:0] MmuWriteDate,
   output logic        MmuInvEn,
   output logic [4:0]  MmuInvOp,
   output logic [9:0]  MmuInvAsid,
   output logic [18:0] MmuInvVppn
);

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

`ifdef TLB_FILL_LFSR_EN
   localparam logic [5:0] FILL_SEED = 6'b000001;
`else
   localparam logic [5:0] FILL_SEED = 6'd0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state;
   logic        readyQ;

   logic [2:0]  reqOp_p0;
   logic [5:0]  reqIndex_p0;
   logic [88:0] reqEntry_p0;
   logic [9:0]  reqAsid_p0;
   logic [18:0] reqVppn_p0;
   logic [4:0]  reqInvOp_p0;
   logic        reqErr_p0;
   logic [5:0]  wrAddr_p0;

   logic        srchStb_p1;
   logic        wrStb_p1;
   logic        invStb_p1;

   logic        vld_p2;
   logic        flushReq_p2;
   logic [2:0]  respOp_p2;
   logic        respHit_p2;
   logic [5:0]  respIndex_p2;
   logic [88:0] respEntry_p2;
   logic        respErr_p2;

   logic [5:0]  fillIdx;
   logic        reqIllegal;
   logic        abortNow;

   function automatic logic isIllegal(input logic [2:0] op, input logic [4:0] invOp);
      return (op > OP_INV) || ((op == OP_INV) && (invOp > 5'd6));
   endfunction

   // Fibonacci x^6+x^5+1 taps bits 5 and 4; the all-zero state is unreachable from the seed.
   function automatic logic [5:0] nextFill(input logic [5:0] cur);
`ifdef TLB_FILL_LFSR_EN
      return {cur[4:0], cur[5] ^ cur[4]};
`else
      return cur + 6'd1;
`endif
   endfunction

   assign reqIllegal = isIllegal(ReqOp, ReqInvOp);
   assign abortNow   = Flush | Rest;

   always_ff @(posedge Clk) begin
      if (Rest) begin
         state        <= IDLE;
         readyQ       <= 1'b1;
         reqOp_p0     <= '0;
         reqIndex_p0  <= '0;
         reqEntry_p0  <= '0;
         reqAsid_p0   <= '0;
         reqVppn_p0   <= '0;
         reqInvOp_p0  <= '0;
         reqErr_p0    <= 1'b0;
         wrAddr_p0    <= '0;
         srchStb_p1   <= 1'b0;
         wrStb_p1     <= 1'b0;
         invStb_p1    <= 1'b0;
         vld_p2       <= 1'b0;
         flushReq_p2  <= 1'b0;
         respOp_p2    <= '0;
         respHit_p2   <= 1'b0;
         respIndex_p2 <= '0;
         respEntry_p2 <= '0;
         respErr_p2   <= 1'b0;
         fillIdx      <= FILL_SEED;
      end else begin
         srchStb_p1  <= 1'b0;
         wrStb_p1    <= 1'b0;
         invStb_p1   <= 1'b0;
         vld_p2      <= 1'b0;
         flushReq_p2 <= 1'b0;
         case (state)
            // p0: accept and latch the request; strobes for ISSUE are prepared here
            IDLE: begin
               if (ReqValid) begin
                  reqOp_p0    <= ReqOp;
                  reqIndex_p0 <= ReqIndex;
                  reqEntry_p0 <= ReqEntry;
                  reqAsid_p0  <= ReqAsid;
                  reqVppn_p0  <= ReqVppn;
                  reqInvOp_p0 <= ReqInvOp;
                  reqErr_p0   <= reqIllegal;
                  wrAddr_p0   <= (ReqOp == OP_FILL) ? fillIdx : ReqIndex;
                  srchStb_p1  <= !reqIllegal && (ReqOp == OP_SRCH);
                  wrStb_p1    <= !reqIllegal && ((ReqOp == OP_WR) || (ReqOp == OP_FILL));
                  invStb_p1   <= !reqIllegal && (ReqOp == OP_INV);
                  readyQ      <= 1'b0;
                  state       <= ISSUE;
               end
            end
            // p1: strobe cycle; a flush here means nothing reached the MMU
            ISSUE: begin
               if (Flush) begin
                  readyQ <= 1'b1;
                  state  <= IDLE;
               end else begin
                  if (wrStb_p1 && (reqOp_p0 == OP_FILL))
                     fillIdx <= nextFill(fillIdx);
                  state <= WAIT;
               end
            end
            // p2: MMU results are valid now; build the response image
            WAIT: begin
               if (Flush) begin
                  readyQ <= 1'b1;
                  state  <= IDLE;
               end else begin
                  vld_p2      <= 1'b1;
                  respOp_p2   <= reqOp_p0;
                  respErr_p2  <= reqErr_p0;
                  respHit_p2  <= !reqErr_p0 && (reqOp_p0 == OP_SRCH) && MmuSerchHit;
                  respEntry_p2 <= (!reqErr_p0 && (reqOp_p0 == OP_RD)) ? MmuReadDate : '0;
                  flushReq_p2 <= !reqErr_p0 && ((reqOp_p0 == OP_WR) || (reqOp_p0 == OP_FILL)
                                                || (reqOp_p0 == OP_INV));
                  if (reqErr_p0) begin
                     respIndex_p2 <= '0;
                  end else begin
                     case (reqOp_p0)
                        OP_SRCH:      respIndex_p2 <= MmuSerchIdx;
                        OP_RD, OP_WR: respIndex_p2 <= reqIndex_p0;
                        OP_FILL:      respIndex_p2 <= wrAddr_p0;
                        default:      respIndex_p2 <= '0;
                     endcase
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               respOp_p2    <= '0;
               respHit_p2   <= 1'b0;
               respIndex_p2 <= '0;
               respEntry_p2 <= '0;
               respErr_p2   <= 1'b0;
               readyQ       <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               readyQ <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Strobes and the completion pulse are gated in the same cycle a flush or reset arrives.
   assign ReqReady       = readyQ;
   assign MmuSerchAble   = srchStb_p1 & ~abortNow;
   assign MmuWriteAble   = wrStb_p1 & ~abortNow;
   assign MmuInvEn       = invStb_p1 & ~abortNow;
   assign MmuSerchInfrom = {reqVppn_p0, reqAsid_p0};
   assign MmuReadAddr    = reqIndex_p0;
   assign MmuWriteAddr   = wrAddr_p0;
   assign MmuWriteDate   = reqEntry_p0;
   assign MmuInvOp       = reqInvOp_p0;
   assign MmuInvAsid     = reqAsid_p0;
   assign MmuInvVppn     = reqVppn_p0;

   assign RespValid = vld_p2 & ~abortNow;
   assign FlushReq  = flushReq_p2 & ~abortNow;
   assign RespOp    = respOp_p2;
   assign RespHit   = respHit_p2;
   assign RespIndex = respIndex_p2;
   assign RespEntry = respEntry_p2;
   assign RespErr   = respErr_p2;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer: search, read, fills, illegal ops, flush and reset aborts.
module tb_tlb_op_sequencer;
   logic        Clk = 1'b0;
   logic        Rest, Flush, ReqValid, ReqReady;
   logic [2:0]  ReqOp;
   logic [5:0]  ReqIndex;
   logic [88:0] ReqEntry;
   logic [9:0]  ReqAsid;
   logic [18:0] ReqVppn;
   logic [4:0]  ReqInvOp;
   logic        RespValid, RespHit, RespErr, FlushReq;
   logic [2:0]  RespOp;
   logic [5:0]  RespIndex;
   logic [88:0] RespEntry;
   logic        MmuSerchAble, MmuSerchHit;
   logic [28:0] MmuSerchInfrom;
   logic [5:0]  MmuSerchIdx, MmuReadAddr, MmuWriteAddr;
   logic [88:0] MmuReadDate, MmuWriteDate;
   logic        MmuWriteAble, MmuInvEn;
   logic [4:0]  MmuInvOp;
   logic [9:0]  MmuInvAsid;
   logic [18:0] MmuInvVppn;

   int vecs = 0;
   int miss = 0;

   tlb_op_sequencer dut (
      .Clk(Clk), .Rest(Rest), .Flush(Flush), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqOp(ReqOp), .ReqIndex(ReqIndex), .ReqEntry(ReqEntry), .ReqAsid(ReqAsid),
      .ReqVppn(ReqVppn), .ReqInvOp(ReqInvOp), .RespValid(RespValid), .RespOp(RespOp),
      .RespHit(RespHit), .RespIndex(RespIndex), .RespEntry(RespEntry), .RespErr(RespErr),
      .FlushReq(FlushReq), .MmuSerchAble(MmuSerchAble), .MmuSerchInfrom(MmuSerchInfrom),
      .MmuSerchHit(MmuSerchHit), .MmuSerchIdx(MmuSerchIdx), .MmuReadAddr(MmuReadAddr),
      .MmuReadDate(MmuReadDate), .MmuWriteAble(MmuWriteAble), .MmuWriteAddr(MmuWriteAddr),
      .MmuWriteDate(MmuWriteDate), .MmuInvEn(MmuInvEn), .MmuInvOp(MmuInvOp),
      .MmuInvAsid(MmuInvAsid), .MmuInvVppn(MmuInvVppn)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   // Presents a request in an IDLE cycle and returns 2 time units into the ISSUE cycle.
   task automatic issue(input logic [2:0] op, input logic [5:0] idx, input logic [4:0] invOp);
      ReqValid = 1'b1;
      ReqOp    = op;
      ReqIndex = idx;
      ReqInvOp = invOp;
      @(posedge Clk);
      #1;
      ReqValid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      Rest = 1'b1; Flush = 1'b0; ReqValid = 1'b0; ReqOp = '0; ReqIndex = '0;
      ReqEntry = '0; ReqAsid = '0; ReqVppn = '0; ReqInvOp = '0;
      MmuSerchHit = 1'b0; MmuSerchIdx = '0; MmuReadDate = '0;
      tick(); tick();
      Rest = 1'b0;
      #1;
      vecs++; if (ReqReady !== 1'b1) begin miss++; $display("FAIL reset_ready got %b exp 1", ReqReady); end
      vecs++; if ({RespValid, FlushReq, MmuSerchAble, MmuWriteAble, MmuInvEn} !== 5'b0) begin
         miss++; $display("FAIL reset_pulses got %b exp 00000", {RespValid, FlushReq, MmuSerchAble, MmuWriteAble, MmuInvEn}); end
      vecs++; if ({MmuReadAddr, MmuWriteAddr, MmuSerchInfrom, RespIndex} !== '0) begin
         miss++; $display("FAIL reset_fields got %h/%h/%h/%h exp 0", MmuReadAddr, MmuWriteAddr, MmuSerchInfrom, RespIndex); end
      tick();
   endtask

   task automatic test_search();
      MmuSerchHit = 1'b1; MmuSerchIdx = 6'd17;
      ReqVppn = 19'h1234; ReqAsid = 10'h5;
      issue(3'd0, 6'd3, 5'd0);
      vecs++; if (MmuSerchAble !== 1'b1 || MmuWriteAble !== 1'b0 || MmuInvEn !== 1'b0) begin
         miss++; $display("FAIL srch_strobe got %b%b%b exp 100", MmuSerchAble, MmuWriteAble, MmuInvEn); end
      vecs++; if (MmuSerchInfrom !== {19'h1234, 10'h5}) begin
         miss++; $display("FAIL srch_info got %h exp %h", MmuSerchInfrom, {19'h1234, 10'h5}); end
      vecs++; if (ReqReady !== 1'b0) begin miss++; $display("FAIL srch_busy got %b exp 0", ReqReady); end
      tick();
      vecs++; if (MmuSerchAble !== 1'b0 || RespValid !== 1'b0) begin
         miss++; $display("FAIL srch_wait got strobe %b resp %b exp 0 0", MmuSerchAble, RespValid); end
      tick();
      vecs++; if (RespValid !== 1'b1 || RespHit !== 1'b1 || RespIndex !== 6'd17 || FlushReq !== 1'b0 || RespOp !== 3'd0) begin
         miss++; $display("FAIL srch_resp got v%b h%b i%0d f%b op%0d exp v1 h1 i17 f0 op0", RespValid, RespHit, RespIndex, FlushReq, RespOp); end
      tick();
      vecs++; if (RespValid !== 1'b0 || ReqReady !== 1'b1) begin
         miss++; $display("FAIL srch_done got v%b r%b exp v0 r1", RespValid, ReqReady); end
   endtask

   task automatic test_read();
      MmuReadDate = 89'hABC;
      issue(3'd1, 6'd42, 5'd0);
      vecs++; if (MmuReadAddr !== 6'd42 || MmuSerchAble !== 1'b0 || MmuWriteAble !== 1'b0) begin
         miss++; $display("FAIL rd_issue got addr %0d s%b w%b exp 42 0 0", MmuReadAddr, MmuSerchAble, MmuWriteAble); end
      tick();
      vecs++; if (MmuReadAddr !== 6'd42) begin miss++; $display("FAIL rd_wait_addr got %0d exp 42", MmuReadAddr); end
      tick();
      vecs++; if (RespValid !== 1'b1 || RespEntry !== 89'hABC || RespIndex !== 6'd42 || RespHit !== 1'b0 || FlushReq !== 1'b0) begin
         miss++; $display("FAIL rd_resp got v%b e%h i%0d h%b f%b exp v1 eabc i42 h0 f0", RespValid, RespEntry, RespIndex, RespHit, FlushReq); end
      tick();
   endtask

   task automatic test_back_to_back();
      int expIdx[3];
      int writes;
`ifdef TLB_FILL_LFSR_EN
      expIdx[0] = 1; expIdx[1] = 2; expIdx[2] = 4;
`else
      expIdx[0] = 0; expIdx[1] = 1; expIdx[2] = 2;
`endif
      Rest = 1'b1; tick(); Rest = 1'b0;
      ReqEntry = 89'h1_2345_6789;
      ReqValid = 1'b1; ReqOp = 3'd3; ReqIndex = 6'd50;
      writes = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++; if (MmuWriteAble !== 1'b1 || MmuWriteAddr !== 6'(expIdx[i]) || MmuWriteDate !== 89'h1_2345_6789) begin
            miss++; $display("FAIL fill%0d_issue got w%b a%0d exp w1 a%0d", i, MmuWriteAble, MmuWriteAddr, expIdx[i]); end
         tick();
         writes += int'(MmuWriteAble);
         tick();
         writes += int'(MmuWriteAble);
         vecs++; if (RespValid !== 1'b1 || FlushReq !== 1'b1 || RespIndex !== 6'(expIdx[i]) || RespOp !== 3'd3) begin
            miss++; $display("FAIL fill%0d_resp got v%b f%b i%0d exp v1 f1 i%0d", i, RespValid, FlushReq, RespIndex, expIdx[i]); end
         if (i == 2) ReqValid = 1'b0;
         tick();
      end
      vecs++; if (writes !== 0) begin miss++; $display("FAIL fill_extra_strobes got %0d exp 0", writes); end
   endtask

   task automatic test_illegal();
      issue(3'd4, 6'd0, 5'd7);
      vecs++; if ({MmuInvEn, MmuWriteAble, MmuSerchAble} !== 3'b000) begin
         miss++; $display("FAIL inv7_strobe got %b exp 000", {MmuInvEn, MmuWriteAble, MmuSerchAble}); end
      tick(); tick();
      vecs++; if (RespValid !== 1'b1 || RespErr !== 1'b1 || FlushReq !== 1'b0) begin
         miss++; $display("FAIL inv7_resp got v%b e%b f%b exp v1 e1 f0", RespValid, RespErr, FlushReq); end
      tick();
      issue(3'd6, 6'd5, 5'd0);
      vecs++; if ({MmuInvEn, MmuWriteAble, MmuSerchAble} !== 3'b000) begin
         miss++; $display("FAIL op6_strobe got %b exp 000", {MmuInvEn, MmuWriteAble, MmuSerchAble}); end
      tick(); tick();
      vecs++; if (RespValid !== 1'b1 || RespErr !== 1'b1 || FlushReq !== 1'b0 || RespOp !== 3'd6) begin
         miss++; $display("FAIL op6_resp got v%b e%b f%b op%0d exp v1 e1 f0 op6", RespValid, RespErr, FlushReq, RespOp); end
      tick();
      issue(3'd4, 6'd9, 5'd2);
      vecs++; if (MmuInvEn !== 1'b1 || MmuInvOp !== 5'd2) begin
         miss++; $display("FAIL inv2_strobe got en%b op%0d exp en1 op2", MmuInvEn, MmuInvOp); end
      tick(); tick();
      vecs++; if (RespValid !== 1'b1 || RespErr !== 1'b0 || FlushReq !== 1'b1 || RespIndex !== 6'd0) begin
         miss++; $display("FAIL inv2_resp got v%b e%b f%b i%0d exp v1 e0 f1 i0", RespValid, RespErr, FlushReq, RespIndex); end
      tick();
   endtask

   task automatic test_flush_issue();
      int resps;
      issue(3'd2, 6'd9, 5'd0);
      Flush = 1'b1;
      #1;
      vecs++; if (MmuWriteAble !== 1'b0) begin miss++; $display("FAIL flush_issue_wr got %b exp 0", MmuWriteAble); end
      tick();
      Flush = 1'b0;
      #1;
      vecs++; if (ReqReady !== 1'b1) begin miss++; $display("FAIL flush_issue_ready got %b exp 1", ReqReady); end
      resps = 0;
      for (int i = 0; i < 4; i++) begin
         resps += int'(RespValid) + int'(MmuWriteAble);
         tick();
      end
      vecs++; if (resps !== 0) begin miss++; $display("FAIL flush_issue_quiet got %0d exp 0", resps); end
   endtask

   task automatic test_flush_wait();
      int writes;
      int resps;
      issue(3'd2, 6'd9, 5'd0);
      writes = int'(MmuWriteAble);
      vecs++; if (MmuWriteAddr !== 6'd9) begin miss++; $display("FAIL wr_addr got %0d exp 9", MmuWriteAddr); end
      tick();
      Flush = 1'b1;
      #1;
      writes += int'(MmuWriteAble);
      resps = int'(RespValid) + int'(FlushReq);
      tick();
      Flush = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         writes += int'(MmuWriteAble);
         resps += int'(RespValid) + int'(FlushReq);
         tick();
      end
      vecs++; if (writes !== 1) begin miss++; $display("FAIL flush_wait_writes got %0d exp 1", writes); end
      vecs++; if (resps !== 0) begin miss++; $display("FAIL flush_wait_resp got %0d exp 0", resps); end
   endtask

   task automatic test_reset_mid();
      ReqVppn = 19'h7_1111; ReqAsid = 10'h3FF;
      issue(3'd0, 6'd33, 5'd0);
      tick();
      Rest = 1'b1;
      tick();
      Rest = 1'b0;
      #1;
      vecs++; if (ReqReady !== 1'b1 || RespValid !== 1'b0 || MmuSerchAble !== 1'b0) begin
         miss++; $display("FAIL rst_mid_ctl got r%b v%b s%b exp r1 v0 s0", ReqReady, RespValid, MmuSerchAble); end
      vecs++; if ({MmuSerchInfrom, MmuReadAddr, RespIndex, RespEntry, FlushReq, RespHit} !== '0) begin
         miss++; $display("FAIL rst_mid_fields got info %h addr %0d exp 0", MmuSerchInfrom, MmuReadAddr); end
      tick();
      vecs++; if (RespValid !== 1'b0) begin miss++; $display("FAIL rst_mid_noresp got %b exp 0", RespValid); end
   endtask

   initial begin
      test_reset();
      test_search();
      test_read();
      test_back_to_back();
      test_illegal();
      test_flush_issue();
      test_flush_wait();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
